crossing_scheduler: RTL and testbench
=====================================

Name: crossing_scheduler

Overview:
Scheduler that shares the single crossing segment between train A and train B. It latches approach requests from the track sensors and grants the segment to one train at a time, round-robin on contention. It drives the route switches and both trains' direction codes, enforces a clearance gap between crossings, and traps sensor inconsistencies or overstays into a sticky FAULT. It sits directly between the sensor inputs and the switch/motor outputs of the track layout.

Parameters:
CLEAR_CYCLES, 4, idle cycles enforced after a crossing exit before the next grant (legal range 1..2^CNT_W-1)
TIMEOUT_CYCLES, 64, max cycles a granted train may occupy the segment before FAULT (legal range 2..2^CNT_W)
CNT_W, 8, width of the shared clearance/timeout counter

Ports:
Clock  in  1  system clock, all state updates on posedge
RESET_N  in  1  asynchronous, active-low reset
SR  in  [4:1]  sensors: SR[1] A approach, SR[2] A exit, SR[3] B approach, SR[4] B exit; level, synchronous to Clock
SW  out  [3:1]  route switches: 3'b000 = A route, 3'b110 = B route
DA  out  [1:0]  train A command: 2'b00 stop, 2'b01 forward
DB  out  [1:0]  train B command, same encoding
BUSY  out  1  segment granted or in clearance
FAULT  out  1  sticky fault flag

Behaviour:
- Reset (async, RESET_N=0): state IDLE, pendA=pendB=0, last_served=B (A wins first tie), counter=0, sensor history=0; outputs SW=000, DA=DB=00, BUSY=0, FAULT=0. Reset mid-crossing aborts the crossing immediately and drops all pending requests.
- Sensor edges: SR is registered each cycle. An edge is SR[i]=1 with the previous sample 0. Levels held high produce only one edge.
- Outputs are registered and computed from next-state values, so they change on the same edge as the state.
- Approach edge on SR[1] or SR[3] sets pendA or pendB in every state except FAULT. It is ignored if that train is already pending or granted.
- DA=00 when pendA=1 and A is not granted, or in FAULT. Otherwise DA=01. DB follows the same rule.
- States:
  - IDLE: BUSY=0, SW holds its last value. If both trains are pending, grant the one that is not last_served. If one train is pending, grant it. Otherwise stay in IDLE.
  - CROSS_A / CROSS_B: SW=route of the grantee, grantee direction=01, BUSY=1, counter cleared on entry and incremented each cycle.
    - Grantee exit edge -> CLEAR; clear the grantee's pend flag; last_served=grantee.
    - Counter reaches TIMEOUT_CYCLES-1 with no exit -> FAULT.
  - CLEAR: BUSY=1, both routes stopped only per the pend rule, counter counts CLEAR_CYCLES then -> IDLE. Approach edges are still latched.
  - FAULT: DA=DB=00, FAULT=1, SW frozen, BUSY=0. Exit only via reset.
- Latency: approach edge sampled at edge N -> pend set and DA=00 at N. In IDLE, grant (SW route, DA=01) at N+1.
- Fault conditions:
  - Exit edge of the non-granted train in any state.
  - Any exit edge in IDLE or CLEAR.
  - Timeout.
- Simultaneous events:
  - Foreign exit beats own exit -> FAULT.
  - Own exit beats timeout in the same cycle -> CLEAR.
  - Grantee exit with its own new approach in the same cycle -> CLEAR, and pend re-set for the next round.
  - Both approach edges in IDLE in the same cycle -> tie broken by last_served.
- Counter is CNT_W bits, saturating. It is never compared beyond parameter limits.

Decomposition:
- train_pkg: state enum (IDLE, CROSS_A, CROSS_B, CLEAR, FAULT), direction codes DIR_STOP=2'b00 and DIR_FWD=2'b01, route constants ROUTE_A=3'b000 and ROUTE_B=3'b110.
- Sub-module sensor_edge_detect: 4-bit register plus rising-edge vector, with async active-low reset to 0. Instantiated once.

Test Plan:
- Reset held 2 cycles, SR=0000, then released -> SW=000, DA=DB=01, BUSY=0, FAULT=0.
- SR=0001 for 1 cycle -> DA=00 that edge. Next edge: CROSS_A, SW=000, DA=01, BUSY=1. Then SR=0010 -> CLEAR for 4 cycles, then IDLE, BUSY=0.
- SR=0101 from IDLE after reset -> A granted first (DB=00). After A exits (SR=0010) and 4 clear cycles, B is granted with SW=110, DB=01. A second simultaneous tie then grants A.
- Grant A, then SR=1000 (B exit) -> FAULT=1, DA=DB=00, held until RESET_N pulse clears it.
- Grant A with no exit for 64 cycles -> FAULT at cycle 64. Repeat with SR=0010 on cycle 63 -> CLEAR, no fault.
- Grant B, assert RESET_N=0 mid-crossing -> all outputs go to reset values immediately (async). After release, pending flags are 0 and IDLE.

Source files
------------

// File: rtl/train_pkg.sv
// Shared state encoding, train direction codes and route switch settings
// for the single-segment crossing scheduler.
package train_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CROSS_A,
        CROSS_B,
        CLEAR,
        FAULT
    } state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_FWD  = 2'b01;

    localparam logic [3:1] ROUTE_A = 3'b000;
    localparam logic [3:1] ROUTE_B = 3'b110;

endpackage

// File: rtl/crossing_scheduler_if.sv
// Sensor inputs and switch/motor outputs between the track layout and the
// scheduler; master is the layout side, slave is the scheduler.
interface crossing_scheduler_if;

    logic [4:1] SR;
    logic [3:1] SW;
    logic [1:0] DA;
    logic [1:0] DB;
    logic       BUSY;
    logic       FAULT;

    modport master (output SR, input SW, DA, DB, BUSY, FAULT);
    modport slave  (input SR, output SW, DA, DB, BUSY, FAULT);

endinterface

// File: rtl/sensor_edge_detect.sv
// Registers the sensor levels and flags bits that rose since the last sample,
// so a level held high yields exactly one event.
module sensor_edge_detect #(
    parameter int W = 4
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic [W:1]   sr,
    output logic [W:1]   rise
);

    logic [W:1] sr_q;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) sr_q <= '0;
        else         sr_q <= sr;
    end

    assign rise = sr & ~sr_q;

endmodule

// File: rtl/crossing_scheduler.sv
// Grants the shared crossing to train A or B (round-robin on ties), drives
// switches and train commands, and traps sensor inconsistencies or overstays.
module crossing_scheduler
    import train_pkg::*;
#(
    parameter int CLEAR_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                 Clock,
    input  logic                 RESET_N,
    crossing_scheduler_if.slave  bus
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    logic [4:1] rise;
    logic       apr_a, ext_a, apr_b, ext_b;

    state_t           state, st_n;
    logic             pend_a, pend_b, pa_n, pb_n;
    logic             last_b, lb_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;

    logic [3:1] sw_q, sw_n;
    logic [1:0] da_q, db_q, da_n, db_n;
    logic       busy_q, fault_q, busy_n, fault_n;

    sensor_edge_detect #(.W(4)) u_edge (
        .gclk   (Clock),
        .grst_n (RESET_N),
        .sr     (bus.SR),
        .rise   (rise)
    );

    assign apr_a = rise[1];
    assign ext_a = rise[2];
    assign apr_b = rise[3];
    assign ext_b = rise[4];

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        st_n  = state;
        pa_n  = pend_a;
        pb_n  = pend_b;
        lb_n  = last_b;
        cnt_n = cnt_inc;

        // A request from the train already holding the segment is redundant.
        if (state != FAULT) begin
            if (apr_a && state != CROSS_A) pa_n = 1'b1;
            if (apr_b && state != CROSS_B) pb_n = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (ext_a || ext_b)                     st_n = FAULT;
                else if (pend_a && (!pend_b || last_b)) st_n = CROSS_A;
                else if (pend_b)                        st_n = CROSS_B;
            end
            CROSS_A: begin
                if (ext_b) st_n = FAULT;
                else if (ext_a) begin
                    st_n  = CLEAR;
                    cnt_n = '0;
                    pa_n  = apr_a;  // back-to-back approach queues the next round
                    lb_n  = 1'b0;
                end
                else if (cnt == TO_LAST) st_n = FAULT;
            end
            CROSS_B: begin
                if (ext_a) st_n = FAULT;
                else if (ext_b) begin
                    st_n  = CLEAR;
                    cnt_n = '0;
                    pb_n  = apr_b;
                    lb_n  = 1'b1;
                end
                else if (cnt == TO_LAST) st_n = FAULT;
            end
            CLEAR: begin
                if (ext_a || ext_b) st_n = FAULT;
                else if (cnt == CLR_LAST) begin
                    st_n  = IDLE;
                    cnt_n = '0;
                end
            end
            FAULT:   cnt_n = cnt;
            default: st_n  = FAULT;
        endcase
    end

    // Outputs are registered from next-state values so they move with the state.
    always_comb begin
        sw_n = sw_q;
        if (st_n == CROSS_A) sw_n = ROUTE_A;
        if (st_n == CROSS_B) sw_n = ROUTE_B;
        da_n    = (st_n == FAULT || (pa_n && st_n != CROSS_A)) ? DIR_STOP : DIR_FWD;
        db_n    = (st_n == FAULT || (pb_n && st_n != CROSS_B)) ? DIR_STOP : DIR_FWD;
        busy_n  = (st_n == CROSS_A) || (st_n == CROSS_B) || (st_n == CLEAR);
        fault_n = (st_n == FAULT);
    end

    always_ff @(posedge Clock or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            pend_a  <= 1'b0;
            pend_b  <= 1'b0;
            last_b  <= 1'b1;
            cnt     <= '0;
            sw_q    <= ROUTE_A;
            da_q    <= DIR_STOP;
            db_q    <= DIR_STOP;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= st_n;
            pend_a  <= pa_n;
            pend_b  <= pb_n;
            last_b  <= lb_n;
            cnt     <= cnt_n;
            sw_q    <= sw_n;
            da_q    <= da_n;
            db_q    <= db_n;
            busy_q  <= busy_n;
            fault_q <= fault_n;
        end
    end

    assign bus.SW    = sw_q;
    assign bus.DA    = da_q;
    assign bus.DB    = db_q;
    assign bus.BUSY  = busy_q;
    assign bus.FAULT = fault_q;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed vector table for the crossing scheduler plus hand sequences for
// timeout, exit-at-timeout and asynchronous reset mid-crossing.
module tb_crossing_scheduler;
    import train_pkg::*;

    localparam logic [1:0] S  = DIR_STOP;
    localparam logic [1:0] F  = DIR_FWD;
    localparam logic [3:1] RA = ROUTE_A;
    localparam logic [3:1] RB = ROUTE_B;

    logic Clock   = 1'b0;
    logic RESET_N = 1'b0;

    crossing_scheduler_if bus ();

    crossing_scheduler #(
        .CLEAR_CYCLES   (4),
        .TIMEOUT_CYCLES (64),
        .CNT_W          (8)
    ) dut (
        .Clock   (Clock),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst;
        logic [4:1] sr;
        logic [3:1] sw;
        logic [1:0] da;
        logic [1:0] db;
        logic       busy;
        logic       fault;
    } vec_t;

    vec_t tbl[$];
    int   applied     = 0;
    int   miscompares = 0;

    function automatic void v(logic rst, logic [4:1] sr, logic [3:1] sw,
                              logic [1:0] da, logic [1:0] db, logic busy, logic fault);
        vec_t t;
        t.rst = rst; t.sr = sr; t.sw = sw; t.da = da; t.db = db; t.busy = busy; t.fault = fault;
        tbl.push_back(t);
    endfunction

    task automatic step(input logic rst, input logic [4:1] sr);
        @(negedge Clock);
        RESET_N = !rst;
        bus.SR  = sr;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:1] sw, input logic [1:0] da,
                         input logic [1:0] db, input logic busy, input logic fault);
        applied++;
        if ({bus.SW, bus.DA, bus.DB, bus.BUSY, bus.FAULT} !== {sw, da, db, busy, fault}) begin
            miscompares++;
            $display("FAIL %s: got SW=%b DA=%b DB=%b BUSY=%b FAULT=%b, want SW=%b DA=%b DB=%b BUSY=%b FAULT=%b",
                     tag, bus.SW, bus.DA, bus.DB, bus.BUSY, bus.FAULT, sw, da, db, busy, fault);
        end
    endtask

    initial begin
        bus.SR = 4'b0000;

        // reset held two cycles, then a single A crossing
        v(1, 4'b0000, RA, S, S, 0, 0);
        v(1, 4'b0000, RA, S, S, 0, 0);
        v(0, 4'b0000, RA, F, F, 0, 0);
        v(0, 4'b0001, RA, S, F, 0, 0);
        v(0, 4'b0000, RA, F, F, 1, 0);
        v(0, 4'b0000, RA, F, F, 1, 0);
        v(0, 4'b0010, RA, F, F, 1, 0);
        v(0, 4'b0000, RA, F, F, 1, 0);
        v(0, 4'b0000, RA, F, F, 1, 0);
        v(0, 4'b0000, RA, F, F, 1, 0);
        v(0, 4'b0000, RA, F, F, 0, 0);
        // tie after reset: A first, then B, then A again
        v(1, 4'b0000, RA, S, S, 0, 0);
        v(0, 4'b0000, RA, F, F, 0, 0);
        v(0, 4'b0101, RA, S, S, 0, 0);
        v(0, 4'b0000, RA, F, S, 1, 0);
        v(0, 4'b0010, RA, F, S, 1, 0);
        v(0, 4'b0000, RA, F, S, 1, 0);
        v(0, 4'b0000, RA, F, S, 1, 0);
        v(0, 4'b0000, RA, F, S, 1, 0);
        v(0, 4'b0000, RA, F, S, 0, 0);
        v(0, 4'b0000, RB, F, F, 1, 0);
        v(0, 4'b1000, RB, F, F, 1, 0);
        v(0, 4'b0000, RB, F, F, 1, 0);
        v(0, 4'b0000, RB, F, F, 1, 0);
        v(0, 4'b0000, RB, F, F, 1, 0);
        v(0, 4'b0000, RB, F, F, 0, 0);
        v(0, 4'b0101, RB, S, S, 0, 0);
        v(0, 4'b0000, RA, F, S, 1, 0);
        // foreign exit while A holds the segment -> sticky fault
        v(0, 4'b1000, RA, S, S, 0, 1);
        v(0, 4'b0000, RA, S, S, 0, 1);
        v(0, 4'b0001, RA, S, S, 0, 1);
        v(1, 4'b0000, RA, S, S, 0, 0);
        v(0, 4'b0000, RA, F, F, 0, 0);
        // exit edge in IDLE
        v(0, 4'b0010, RA, S, S, 0, 1);
        v(1, 4'b0000, RA, S, S, 0, 0);
        v(0, 4'b0000, RA, F, F, 0, 0);
        // B exit with its own new approach: re-pended for the next round
        v(0, 4'b0100, RA, F, S, 0, 0);
        v(0, 4'b0000, RB, F, F, 1, 0);
        v(0, 4'b1100, RB, F, S, 1, 0);
        v(0, 4'b0000, RB, F, S, 1, 0);
        v(0, 4'b0000, RB, F, S, 1, 0);
        v(0, 4'b0000, RB, F, S, 1, 0);
        v(0, 4'b0000, RB, F, S, 0, 0);
        v(0, 4'b0000, RB, F, F, 1, 0);
        // exit edge during CLEAR
        v(0, 4'b1000, RB, F, F, 1, 0);
        v(0, 4'b0000, RB, F, F, 1, 0);
        v(0, 4'b1000, RB, S, S, 0, 1);
        v(1, 4'b0000, RA, S, S, 0, 0);
        v(0, 4'b0000, RA, F, F, 0, 0);
        // foreign and own exit together -> fault wins
        v(0, 4'b0001, RA, S, F, 0, 0);
        v(0, 4'b0000, RA, F, F, 1, 0);
        v(0, 4'b1010, RA, S, S, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].sr);
            check($sformatf("vec%0d", i), tbl[i].sw, tbl[i].da, tbl[i].db, tbl[i].busy, tbl[i].fault);
        end

        // overstay: fault on the 64th cycle of the crossing
        step(1, 4'b0000);
        step(0, 4'b0001);
        step(0, 4'b0000);
        check("to_grant", RA, F, F, 1, 0);
        for (int k = 1; k < 64; k++) begin
            step(0, 4'b0000);
            check($sformatf("to_wait%0d", k), RA, F, F, 1, 0);
        end
        step(0, 4'b0000);
        check("to_fault", RA, S, S, 0, 1);

        // exit coinciding with the timeout cycle wins
        step(1, 4'b0000);
        step(0, 4'b0001);
        step(0, 4'b0000);
        for (int k = 1; k < 64; k++) step(0, 4'b0000);
        check("to2_before", RA, F, F, 1, 0);
        step(0, 4'b0010);
        check("to2_exit", RA, F, F, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 4'b0000);
        check("to2_clear", RA, F, F, 1, 0);
        step(0, 4'b0000);
        check("to2_idle", RA, F, F, 0, 0);

        // asynchronous reset in the middle of a B crossing
        step(1, 4'b0000);
        step(0, 4'b0100);
        step(0, 4'b0000);
        check("ar_grant", RB, F, F, 1, 0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("ar_async", RA, S, S, 0, 0);
        step(1, 4'b0000);
        check("ar_held", RA, S, S, 0, 0);
        step(0, 4'b0000);
        check("ar_idle", RA, F, F, 0, 0);
        step(0, 4'b0000);
        check("ar_nopend", RA, F, F, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
